// File: rtl/weight_enum_pkg.sv
// Shared widths, FSM state type and bit-twiddling helpers for the weight enumerator.
package weight_enum_pkg;

    localparam int unsigned W     = 8;
    localparam int unsigned K_W   = 4;
    localparam int unsigned IDX_W = 7;
    localparam int unsigned SUM_W = W + 1;
    localparam int unsigned K_MAX = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Trailing-zero count; returns W for an all-zero word.
    function automatic logic [K_W-1:0] ctz(input logic [W-1:0] x);
        logic [K_W-1:0] n;
        n = K_W'(W);
        for (int i = W - 1; i >= 0; i--) begin
            if (x[i]) n = K_W'(i);
        end
        return n;
    endfunction

    // True when all ones sit contiguously at the MSB end (includes 0x00 and 0xFF).
    function automatic logic is_msb_packed(input logic [W-1:0] x);
        logic [W-1:0] inv;
        inv = ~x;
        return (inv & (inv + W'(1))) == '0;
    endfunction

endpackage

// File: rtl/weight_enum_if.sv
// Request/stream bundle between the enumerator and its consumer.
interface weight_enum_if;
    import weight_enum_pkg::*;

    logic             start;
    logic [K_W-1:0]   k;
    logic             out_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, k, out_ready,
        input  out_valid, out_data, out_idx, out_last, busy, done, err
    );

    modport slave (
        input  start, k, out_ready,
        output out_valid, out_data, out_idx, out_last, busy, done, err
    );

endinterface

// File: rtl/weight_enum_next_comb.sv
// Combinational successor of an equal-weight word (lowest-set-bit method) and its last flag.
module next_comb
    import weight_enum_pkg::*;
(
    input  logic [W-1:0] word_i,
    output logic [W-1:0] next_o,
    output logic         next_last_o
);

    logic [SUM_W-1:0] x;
    logic [SUM_W-1:0] c;
    logic [SUM_W-1:0] r;
    logic [SUM_W-1:0] tail;

    always_comb begin
        x           = SUM_W'(word_i);
        c           = x & (~x + SUM_W'(1));
        r           = x + c;
        tail        = ((r ^ x) >> 2) >> ctz(word_i);
        next_o      = W'(r | tail);
        next_last_o = is_msb_packed(next_o);
    end

endmodule

// File: rtl/weight_enum.sv
// Streams every 8-bit word of popcount k in ascending order over a valid/ready handshake.
module weight_enum
    import weight_enum_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    weight_enum_if.slave  bus
);

    state_e           state_q, state_d;
    logic [W-1:0]     data_q,  data_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic             last_q,  last_d;
    logic             valid_q, valid_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic             err_q,   err_d;

    logic [W-1:0]     nxt_word;
    logic             nxt_last;
    logic [W-1:0]     load_word;

    next_comb u_next (
        .word_i      (data_q),
        .next_o      (nxt_word),
        .next_last_o (nxt_last)
    );

    // (1 << k) - 1 needs the ninth bit for k = 8.
    assign load_word = W'((SUM_W'(1) << bus.k) - SUM_W'(1));

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        last_d  = last_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.k > K_W'(K_MAX)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        data_d  = load_word;
                        idx_d   = '0;
                        last_d  = is_msb_packed(load_word);
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (valid_q && bus.out_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                        data_d  = '0;
                        idx_d   = '0;
                        last_d  = 1'b0;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        data_d  = nxt_word;
                        idx_d   = idx_q + IDX_W'(1);
                        last_d  = nxt_last;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_idx   = idx_q;
    assign bus.out_last  = last_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_weight_enum.sv
// Directed bench for weight_enum: reset, k=0/1/2/3/4/8 sequences, stalls, err and mid-run reset.
module tb_weight_enum;
    import weight_enum_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_bad = 0;

    weight_enum_if bus ();

    weight_enum dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference successor: brute-force scan for the next value with the same popcount.
    function automatic int next_word(input int v, input int kk);
        int n;
        n = v + 1;
        while (n < 256 && $countones(8'(n)) != kk) n++;
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.k         = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", bus.out_valid); end
        n_vec++; if (bus.out_data !== 8'h00) begin n_bad++; $display("FAIL rst_data got %h want 00", bus.out_data); end
        n_vec++; if (bus.out_idx !== 7'd0) begin n_bad++; $display("FAIL rst_idx got %0d want 0", bus.out_idx); end
        n_vec++; if (bus.out_last !== 1'b0) begin n_bad++; $display("FAIL rst_last got %b want 0", bus.out_last); end
        n_vec++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
            n_bad++; $display("FAIL rst_flags got busy=%b done=%b err=%b want 0 0 0", bus.busy, bus.done, bus.err);
        end
        #2 rst_n = 1'b1;
        tick();
        n_vec++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL post_rst_valid got %b want 0", bus.out_valid); end
    endtask

    task automatic test_k0();
        bus.k = 4'd0; bus.start = 1'b1; bus.out_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        n_vec++; if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1) begin
            n_bad++; $display("FAIL k0_valid got valid=%b busy=%b want 1 1", bus.out_valid, bus.busy);
        end
        n_vec++; if (bus.out_data !== 8'h00 || bus.out_idx !== 7'd0) begin
            n_bad++; $display("FAIL k0_word got %h/%0d want 00/0", bus.out_data, bus.out_idx);
        end
        n_vec++; if (bus.out_last !== 1'b1) begin n_bad++; $display("FAIL k0_last got %b want 1", bus.out_last); end
        tick();
        n_vec++; if (bus.done !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_bad++; $display("FAIL k0_done got done=%b valid=%b busy=%b want 1 0 0", bus.done, bus.out_valid, bus.busy);
        end
        tick();
        n_vec++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL k0_done_pulse got %b want 0", bus.done); end
    endtask

    task automatic test_k1_stream();
        bus.k = 4'd1; bus.start = 1'b1; bus.out_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_vec++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(1 << i) || bus.out_idx !== 7'(i)) begin
                n_bad++; $display("FAIL k1_word%0d got v=%b %h/%0d want 1 %h/%0d", i, bus.out_valid, bus.out_data, bus.out_idx, 8'(1 << i), i);
            end
            n_vec++; if (bus.out_last !== (i == 7)) begin
                n_bad++; $display("FAIL k1_last%0d got %b want %b", i, bus.out_last, (i == 7));
            end
            tick();
        end
        n_vec++; if (bus.done !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL k1_end got done=%b valid=%b want 1 0", bus.done, bus.out_valid);
        end
    endtask

    task automatic test_k4_stall();
        int  exp_w, exp_i, accepted, last_w;
        bit  finished, rdy;
        exp_w = 8'h0F; exp_i = 0; accepted = 0; last_w = -1; finished = 0;
        bus.k = 4'd4; bus.start = 1'b1; bus.out_ready = 1'b0;
        tick();
        bus.start = 1'b0;
        for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
            n_vec++; if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1) begin
                n_bad++; $display("FAIL k4_valid cyc%0d got v=%b busy=%b want 1 1", cyc, bus.out_valid, bus.busy);
                break;
            end
            n_vec++; if (bus.out_data !== 8'(exp_w) || bus.out_idx !== 7'(exp_i)) begin
                n_bad++; $display("FAIL k4_word cyc%0d got %h/%0d want %h/%0d", cyc, bus.out_data, bus.out_idx, 8'(exp_w), exp_i);
            end
            n_vec++; if (bus.out_last !== (exp_i == 69) || $countones(bus.out_data) != 4) begin
                n_bad++; $display("FAIL k4_last cyc%0d got last=%b pop=%0d want %b 4", cyc, bus.out_last, $countones(bus.out_data), (exp_i == 69));
            end
            rdy = 1'($urandom_range(0, 1));
            bus.out_ready = rdy;
            tick();
            if (rdy) begin
                accepted++;
                if (exp_i == 69) begin
                    finished = 1;
                    last_w   = exp_w;
                end else begin
                    exp_w = next_word(exp_w, 4);
                    exp_i++;
                end
            end
        end
        n_vec++; if (!finished || accepted != 70 || last_w != 8'hF0) begin
            n_bad++; $display("FAIL k4_count got fin=%0d n=%0d last=%h want 1 70 f0", finished, accepted, last_w);
        end
        n_vec++; if (bus.done !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_bad++; $display("FAIL k4_done got done=%b valid=%b busy=%b want 1 0 0", bus.done, bus.out_valid, bus.busy);
        end
        bus.out_ready = 1'b1;
    endtask

    task automatic test_err();
        bus.k = 4'd9; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n_vec++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL err9_pulse got %b want 1", bus.err); end
        n_vec++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_bad++; $display("FAIL err9_flags got v=%b busy=%b done=%b want 0 0 0", bus.out_valid, bus.busy, bus.done);
        end
        tick();
        n_vec++; if (bus.err !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL err9_clear got err=%b v=%b want 0 0", bus.err, bus.out_valid);
        end
        bus.k = 4'd15; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n_vec++; if (bus.err !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL err15 got err=%b v=%b want 1 0", bus.err, bus.out_valid);
        end
        tick();
    endtask

    task automatic test_start_ignored();
        int exp_w;
        exp_w = 8'h03;
        bus.k = 4'd2; bus.start = 1'b1; bus.out_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 28; i++) begin
            n_vec++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(exp_w) || bus.out_idx !== 7'(i) || bus.out_last !== (i == 27)) begin
                n_bad++; $display("FAIL k2_word%0d got v=%b %h/%0d last=%b want 1 %h/%0d %b",
                                  i, bus.out_valid, bus.out_data, bus.out_idx, bus.out_last, 8'(exp_w), i, (i == 27));
            end
            if (i == 5 || i == 27) begin
                bus.start = 1'b1; bus.k = 4'd3;
            end else begin
                bus.start = 1'b0;
            end
            tick();
            exp_w = next_word(exp_w, 2);
        end
        bus.start = 1'b0;
        n_vec++; if (bus.done !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_bad++; $display("FAIL k2_end got done=%b v=%b busy=%b want 1 0 0", bus.done, bus.out_valid, bus.busy);
        end
        tick();
        n_vec++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL k2_no_restart got v=%b want 0", bus.out_valid); end
        bus.k = 4'd8; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n_vec++; if (bus.out_data !== 8'hFF || bus.out_idx !== 7'd0 || bus.out_last !== 1'b1 || bus.out_valid !== 1'b1) begin
            n_bad++; $display("FAIL k8_word got %h/%0d last=%b v=%b want ff/0 1 1", bus.out_data, bus.out_idx, bus.out_last, bus.out_valid);
        end
        tick();
        n_vec++; if (bus.done !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL k8_done got done=%b v=%b want 1 0", bus.done, bus.out_valid);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        int exp_w;
        exp_w = 8'h07;
        bus.k = 4'd3; bus.start = 1'b1; bus.out_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            n_vec++; if (bus.out_data !== 8'(exp_w) || bus.out_idx !== 7'(i)) begin
                n_bad++; $display("FAIL k3_word%0d got %h/%0d want %h/%0d", i, bus.out_data, bus.out_idx, 8'(exp_w), i);
            end
            if (i == 10) break;
            tick();
            exp_w = next_word(exp_w, 3);
        end
        rst_n = 1'b0;
        #1;
        n_vec++; if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_idx !== 7'd0 || bus.out_last !== 1'b0) begin
            n_bad++; $display("FAIL midrst_word got v=%b %h/%0d last=%b want 0 00/0 0", bus.out_valid, bus.out_data, bus.out_idx, bus.out_last);
        end
        n_vec++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
            n_bad++; $display("FAIL midrst_flags got busy=%b done=%b err=%b want 0 0 0", bus.busy, bus.done, bus.err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_vec++; if (bus.done !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL midrst_nodone got done=%b v=%b want 0 0", bus.done, bus.out_valid);
        end
        bus.k = 4'd3; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n_vec++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h07 || bus.out_idx !== 7'd0) begin
            n_bad++; $display("FAIL midrst_restart got v=%b %h/%0d want 1 07/0", bus.out_valid, bus.out_data, bus.out_idx);
        end
    endtask

    initial begin
        test_reset();
        test_k0();
        test_k1_stream();
        test_k4_stall();
        test_err();
        test_start_ignored();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1, "watchdog");
    end

endmodule
